pwm_core: RTL and testbench

Counter/comparator stage that consumes the prescaler's divided clock and produces the PWM waveform. The prescaled clock is treated as a tick source inside the single `clk` domain, not as a clock. Each tick advances a period counter, and a registered comparator drives the output. Period and duty updates are double-buffered and take effect only at period boundaries, so no glitched cycles are produced. Optional dead-band logic generates a non-overlapping complementary pair for half-bridge drivers.

---
 rtl/pwm_pkg.sv | 7 +
 rtl/pwm_deadband.sv | 45 ++++
 rtl/pwm_core.sv | 109 ++++++++++
 tb/tb_pwm_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM counter/comparator slice.
package pwm_pkg;
    localparam int unsigned PWM_WIDTH    = 8;
    localparam int unsigned PWM_DB_WIDTH = 4;
    // per_act resets to all-ones; sliced to WIDTH (up to 32 bits) at the user
    localparam logic [31:0] PWM_PER_ONES = '1;
endpackage

// File: rtl/pwm_deadband.sv
// Dead-band generator: delays each rising edge of raw/~raw by db clk cycles
// and drops both outputs on any raw edge, so the pair never overlaps.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int unsigned DB_WIDTH = PWM_DB_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw,
    input  logic [DB_WIDTH-1:0] db,
    output logic                pwm_hi,
    output logic                pwm_lo
);

    logic                raw_q;
    logic [DB_WIDTH-1:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q  <= 1'b0;
            dcnt   <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            raw_q <= raw;
            if (raw != raw_q) begin
                // a new edge restarts the gap; a still-running gap is abandoned
                dcnt   <= db;
                pwm_hi <= (db == '0) ? raw  : 1'b0;
                pwm_lo <= (db == '0) ? ~raw : 1'b0;
            end else if (dcnt != '0) begin
                dcnt <= dcnt - DB_WIDTH'(1);
                if (dcnt == DB_WIDTH'(1)) begin
                    pwm_hi <= raw;
                    pwm_lo <= ~raw;
                end
            end else begin
                pwm_hi <= raw;
                pwm_lo <= ~raw;
            end
        end
    end

endmodule

// File: rtl/pwm_core.sv
// pwm_core: tick-driven period counter with a registered comparator and
// double-buffered period/duty. Define PWM_DEADBAND_EN for dead-band outputs.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = PWM_WIDTH,
    parameter int unsigned DB_WIDTH = PWM_DB_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                presc_clk,
    input  logic                presc_bypass,
    input  logic                en,
    input  logic [WIDTH-1:0]    period,
    input  logic [WIDTH-1:0]    duty,
    input  logic                load,
    input  logic [DB_WIDTH-1:0] db,
    output logic                pwm_out,
    output logic                pwm_n,
    output logic                period_end
);

    localparam logic [WIDTH-1:0] PER_RST = PWM_PER_ONES[WIDTH-1:0];

    logic             presc_q;
    logic             tick;
    logic             wrap;
    logic             apply;
    logic             pend;
    logic             raw;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] per_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] per_pend;
    logic [WIDTH-1:0] duty_pend;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] per_act_next;
    logic [WIDTH-1:0] duty_act_next;

    assign tick = presc_bypass | (presc_clk & ~presc_q);

    // Pending values move to the active set at a wrap or whenever disabled.
    always_comb begin
        wrap     = (cnt == per_act);
        apply    = 1'b0;
        cnt_next = cnt;
        if (!en) begin
            cnt_next = '0;
            apply    = pend;
        end else if (tick) begin
            if (wrap) begin
                cnt_next = '0;
                apply    = pend;
            end else begin
                cnt_next = cnt + WIDTH'(1);
            end
        end
        per_act_next  = apply ? per_pend  : per_act;
        duty_act_next = apply ? duty_pend : duty_act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= 1'b0;
            cnt        <= '0;
            per_act    <= PER_RST;
            duty_act   <= '0;
            per_pend   <= '0;
            duty_pend  <= '0;
            pend       <= 1'b0;
            raw        <= 1'b0;
            period_end <= 1'b0;
        end else begin
            presc_q    <= presc_clk;
            cnt        <= cnt_next;
            per_act    <= per_act_next;
            duty_act   <= duty_act_next;
            raw        <= en & (cnt_next < duty_act_next);
            period_end <= en & tick & wrap;
            // a load coinciding with an apply becomes the next pending set
            if (load) begin
                per_pend  <= period;
                duty_pend <= duty;
                pend      <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

`ifdef PWM_DEADBAND_EN
    pwm_deadband #(
        .DB_WIDTH(DB_WIDTH)
    ) u_deadband (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw),
        .db     (db),
        .pwm_hi (pwm_out),
        .pwm_lo (pwm_n)
    );
`else
    logic [DB_WIDTH-1:0] unused_db;
    assign unused_db = db;
    assign pwm_out   = raw;
    assign pwm_n     = ~raw;
`endif

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: a rule-level model queues the expected
// outputs per clk edge and a monitor pops and compares them after each edge.
module tb_pwm_core;
    localparam int unsigned W   = 8;
    localparam int unsigned DBW = 4;
`ifdef PWM_DEADBAND_EN
    localparam int   LAT    = 1;
    localparam logic PN_RST = 1'b0;
`else
    localparam int   LAT    = 0;
    localparam logic PN_RST = 1'b1;
`endif

    bit             clk;
    logic           rst_n, presc_clk, presc_bypass, en, load;
    logic [W-1:0]   period, duty;
    logic [DBW-1:0] db;
    logic           pwm_out, pwm_n, period_end;

    pwm_core #(.WIDTH(W), .DB_WIDTH(DBW)) dut (
        .clk(clk), .rst_n(rst_n), .presc_clk(presc_clk), .presc_bypass(presc_bypass),
        .en(en), .period(period), .duty(duty), .load(load), .db(db),
        .pwm_out(pwm_out), .pwm_n(pwm_n), .period_end(period_end)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic po; logic pn; logic pe; } exp_t;
    exp_t sb[$];
    int n_checks, n_errors;
    int hi_cnt, lo_cnt, pe_cnt, both_cnt;
    bit done;
    int pmode, ph;

    // reference state: position in period, active and pending settings
    int m_cnt, m_per, m_duty, m_pper, m_pduty;
    bit m_pend, m_pq, m_raw;
    bit rh[$];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_per = (1 << W) - 1; m_duty = 0;
        m_pper = 0; m_pduty = 0; m_pend = 0; m_pq = 0; m_raw = 0;
        rh = {};
        repeat (17) rh.push_back(1'b0);
    endtask

    task automatic model_step(output exp_t e);
        bit tk, wrap_ev, apply;
`ifdef PWM_DEADBAND_EN
        bit hi, lo;
`endif
        e = '0;
        if (rst_n !== 1'b1) begin
            model_reset();
            e.pn = PN_RST;
            return;
        end
        tk = presc_bypass || (presc_clk && !m_pq);
        wrap_ev = 0;
        apply = 0;
        if (!en) begin
            m_cnt = 0;
            apply = m_pend;
        end else if (tk) begin
            if (m_cnt == m_per) begin
                m_cnt = 0; wrap_ev = 1; apply = m_pend;
            end else begin
                m_cnt++;
            end
        end
        if (apply) begin m_per = m_pper; m_duty = m_pduty; end
        if (load) begin
            m_pper = int'(period); m_pduty = int'(duty); m_pend = 1;
        end else if (apply) begin
            m_pend = 0;
        end
        m_pq = presc_clk;
`ifdef PWM_DEADBAND_EN
        // an output is high only after raw held its level for db+1 samples
        hi = 1; lo = 1;
        for (int i = 0; i <= int'(db); i++) begin
            hi &= rh[i];
            lo &= ~rh[i];
        end
`endif
        m_raw = en && (m_cnt < m_duty);
`ifdef PWM_DEADBAND_EN
        rh.push_front(m_raw);
        void'(rh.pop_back());
        e.po = hi; e.pn = lo;
`else
        e.po = m_raw; e.pn = !m_raw;
`endif
        e.pe = wrap_ev;
    endtask

    task automatic cycle(input bit ld);
        exp_t e;
        load = ld;
        case (pmode)
            0:       begin presc_bypass = 1; presc_clk = 1'($urandom_range(0, 1)); end
            1:       begin presc_bypass = 0; presc_clk = ((ph % 4) >= 2); end
            default: begin presc_bypass = 0; presc_clk = 1'($urandom_range(0, 1)); end
        endcase
        ph++;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic clr();
        hi_cnt = 0; lo_cnt = 0; pe_cnt = 0; both_cnt = 0;
    endtask

    task automatic wait_cnt(input int k);
        for (int i = 0; i < 300 && m_cnt != k; i++) cycle(0);
        if (m_cnt != k) begin
            n_checks++; n_errors++;
            $display("FAIL wait_cnt: count %0d never reached %0d", m_cnt, k);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) cycle(0);
        rst_n = 1;
    endtask

    task automatic set_cfg(input int p, input int d);
        en = 0; period = W'(p); duty = W'(d);
        cycle(1);
        cycle(0);
        en = 1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                if (!done) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_empty: no expectation queued at %0t", $time);
                end
            end else begin
                e = sb.pop_front();
                chk_bit("pwm_out", pwm_out, e.po);
                chk_bit("pwm_n", pwm_n, e.pn);
                chk_bit("period_end", period_end, e.pe);
                hi_cnt   += int'(pwm_out === 1'b1);
                lo_cnt   += int'(pwm_n === 1'b1);
                pe_cnt   += int'(period_end === 1'b1);
                both_cnt += int'(pwm_out === 1'b1 && pwm_n === 1'b1);
            end
        end
    end

    initial begin
        rst_n = 1; presc_clk = 0; presc_bypass = 1; en = 0; load = 0;
        period = '0; duty = '0; db = '0; pmode = 0; ph = 0;
        model_reset();
        #1 rst_n = 0;
        #1;
        chk_bit("rst_pwm_out", pwm_out, 1'b0);
        chk_bit("rst_pwm_n", pwm_n, PN_RST);
        chk_bit("rst_period_end", period_end, 1'b0);
        repeat (2) cycle(0);
        rst_n = 1;

        // reset per_act is all-ones: first wrap after 256 ticks
        en = 1; clr();
        repeat (260) cycle(0);
        check("reset_period_wraps", pe_cnt, 1);
        check("reset_duty_low", hi_cnt, 0);

        set_cfg(9, 3);
        repeat (20) cycle(0);
        clr(); repeat (30) cycle(0);
        check("p9d3_high", hi_cnt, 9);
        check("p9d3_pe", pe_cnt, 3);

        pmode = 1;
        set_cfg(4, 2);
        repeat (40) cycle(0);
        clr(); repeat (40) cycle(0);
        check("div4_high", hi_cnt, 16);
        check("div4_pe", pe_cnt, 2);

        pmode = 0;
        set_cfg(9, 3);
        wait_cnt(2);
        duty = 7; cycle(1);
        clr(); repeat (6) cycle(0);
        check("midload_old_duty", hi_cnt, 0);
        clr(); repeat (10) cycle(0);
        check("midload_new_duty", hi_cnt, 7);
        wait_cnt(9);
        duty = 2; cycle(1);
        clr(); repeat (9) cycle(0);
        check("wrapload_deferred", hi_cnt, 6 + LAT);
        clr(); repeat (10) cycle(0);
        check("wrapload_applied", hi_cnt, 2);

        period = 9; duty = 0; cycle(1); repeat (12) cycle(0);
        clr(); repeat (20) cycle(0);
        check("duty0_low", hi_cnt, 0);
        duty = 10; cycle(1); repeat (12) cycle(0);
        clr(); repeat (20) cycle(0);
        check("duty_gt_period_high", hi_cnt, 20);
        period = 0; duty = 1; cycle(1); repeat (12) cycle(0);
        clr(); repeat (20) cycle(0);
        check("period0_high", hi_cnt, 20);
        check("period0_pe", pe_cnt, 20);

        period = 9; duty = 7; cycle(1); repeat (12) cycle(0);
        wait_cnt(5);
        en = 0; cycle(0);
        chk_bit("disable_pe", period_end, 1'b0);
`ifndef PWM_DEADBAND_EN
        chk_bit("disable_pwm_out", pwm_out, 1'b0);
`endif
        en = 1; clr();
        repeat (10) cycle(0);
        check("reenable_high", hi_cnt, 7 - LAT);
        check("reenable_full_period", pe_cnt, 1);

        wait_cnt(1);
        period = 3; duty = 1; cycle(1);
        chk_bit("pre_reset_high", pwm_out, 1'b1);
        rst_n = 0;
        #1;
        chk_bit("async_rst_pwm_out", pwm_out, 1'b0);
        chk_bit("async_rst_pwm_n", pwm_n, PN_RST);
        chk_bit("async_rst_pe", period_end, 1'b0);
        repeat (2) cycle(0);
        rst_n = 1;
        en = 0; repeat (2) cycle(0);
        en = 1; clr();
        repeat (20) cycle(0);
        check("pending_lost_pe", pe_cnt, 0);
        check("pending_lost_high", hi_cnt, 0);

`ifdef PWM_DEADBAND_EN
        db = 2; do_reset(2);
        set_cfg(9, 5);
        repeat (20) cycle(0);
        clr(); repeat (30) cycle(0);
        check("db2_high", hi_cnt, 9);
        check("db2_low", lo_cnt, 9);
        check("db2_overlap", both_cnt, 0);
        db = 6; do_reset(2);
        set_cfg(9, 5);
        repeat (20) cycle(0);
        clr(); repeat (30) cycle(0);
        check("db6_high_suppressed", hi_cnt, 0);
        check("db6_overlap", both_cnt, 0);
        db = 3; do_reset(2);
`endif

        clr();
        for (int i = 0; i < 2400; i++) begin
            bit ld;
            if (i % 400 == 0) pmode = $urandom_range(0, 2);
            ld = ($urandom_range(0, 11) == 0);
            if (ld) begin
                period = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                     : W'($urandom_range(0, 12));
                duty = W'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 63) == 0) en = ~en;
`ifndef PWM_DEADBAND_EN
            db = DBW'($urandom_range(0, 15));
`endif
            if (i == 1500) do_reset(1);
            cycle(ld);
        end
        check("random_overlap", both_cnt, 0);

        done = 1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
